// File: rtl/character_draw_engine.sv
// character_draw_engine: erases the sprite at the last drawn position and redraws it at the
// position reported by the character FSM, one pixel per clock, holding DoneDrawing low while busy.
module character_draw_engine #(
  parameter int unsigned SPRITE_W     = 8,
  parameter int unsigned SPRITE_H     = 8,
  parameter int unsigned LANE_X0      = 16,
  parameter int unsigned LANE_PITCH   = 36,
  parameter int unsigned BASE_Y       = 104,
  parameter logic [2:0]  FG_COLOUR    = 3'b111,
  parameter logic [2:0]  TRANS_COLOUR = 3'b110,
  parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] CurrState,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic [2:0] Colour,
  output logic       Plot,
  output logic       DoneDrawing
);

  localparam int unsigned CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ERASE, S_DRAW} state_t;

  // Invalid position codes collapse onto lane 0.
  function automatic logic [3:0] norm_pos(input logic [3:0] c);
    return (c > 4'd9) ? 4'd0 : c;
  endfunction

  // Left X of the sprite box for a normalised position code.
  function automatic logic [7:0] base_x(input logic [3:0] p);
    int unsigned bx;
    if (p < 4'd4) bx = LANE_X0 + 32'(p) * LANE_PITCH;
    else          bx = LANE_X0 + LANE_PITCH / 2 + 32'((p - 4'd4) >> 1) * LANE_PITCH;
    return 8'(bx);
  endfunction

  state_t           state_q, state_d;
  logic [CXW-1:0]   cx_q, cx_d, cx_adv;
  logic [CYW-1:0]   cy_q, cy_d, cy_adv;
  logic [3:0]       target_q, target_d;
  logic [3:0]       drawn_q, drawn_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic [2:0]       colour_q, colour_d;
  logic             plot_q, plot_d;
  logic [3:0]       pos_n;
  logic [3:0]       box_pos;
  logic             row_end;
  logic             last_px;
  logic             done_c;

  assign X           = x_q;
  assign Y           = y_q;
  assign Colour      = colour_q;
  assign Plot        = plot_q;
  assign DoneDrawing = done_c;

  // Next-state, scan counters and next pixel to present on the registered pixel port.
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    target_d = target_q;
    drawn_d  = drawn_q;
    plot_d   = 1'b0;
    done_c   = 1'b0;

    pos_n   = norm_pos(CurrState);
    row_end = (cx_q == CXW'(SPRITE_W - 1));
    last_px = row_end && (cy_q == CYW'(SPRITE_H - 1));
    cx_adv  = row_end ? '0 : cx_q + CXW'(1);
    cy_adv  = row_end ? cy_q + CYW'(1) : cy_q;

    case (state_q)
      S_INIT: begin
        // First INIT cycle after reset only primes pixel 0 onto the port.
        target_d = 4'd0;
        plot_d   = 1'b1;
        if (plot_q) begin
          if (last_px) begin
            state_d = S_IDLE;
            drawn_d = 4'd0;
            plot_d  = 1'b0;
            cx_d    = '0;
            cy_d    = '0;
          end else begin
            cx_d = cx_adv;
            cy_d = cy_adv;
          end
        end
      end
      S_IDLE: begin
        done_c = (pos_n == drawn_q);
        if (pos_n != drawn_q) begin
          target_d = pos_n;
          state_d  = S_ERASE;
          cx_d     = '0;
          cy_d     = '0;
          plot_d   = 1'b1;
        end
      end
      S_ERASE: begin
        plot_d = 1'b1;
        if (last_px) begin
          state_d = S_DRAW;
          cx_d    = '0;
          cy_d    = '0;
        end else begin
          cx_d = cx_adv;
          cy_d = cy_adv;
        end
      end
      S_DRAW: begin
        if (last_px) begin
          state_d = S_IDLE;
          drawn_d = target_q;
          cx_d    = '0;
          cy_d    = '0;
        end else begin
          plot_d = 1'b1;
          cx_d   = cx_adv;
          cy_d   = cy_adv;
        end
      end
      default: state_d = S_INIT;
    endcase

    box_pos  = (state_d == S_ERASE) ? drawn_q : target_d;
    x_d      = plot_d ? base_x(box_pos) + 8'(cx_d) : 8'd0;
    y_d      = plot_d ? 7'(BASE_Y) + 7'(cy_d) : 7'd0;
    colour_d = !plot_d                  ? 3'b000 :
               (state_d == S_ERASE)     ? BG_COLOUR :
               (target_d < 4'd4)        ? FG_COLOUR : TRANS_COLOUR;
  end

  // State, counters and pixel port registers; reset overrides any scan in progress.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_INIT;
      cx_q     <= '0;
      cy_q     <= '0;
      target_q <= 4'd0;
      drawn_q  <= 4'd0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'b000;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      target_q <= target_d;
      drawn_q  <= drawn_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

endmodule
